// File: rtl/cgol_board_memory.sv
// Double-banked 8x8 board store: reads hit the read bank, writes fill the write bank, CYCLE_REGISTERS copies write->read one row per clock.
// Read data 1 clock after the request; o_done is 9 clocks after the entry edge; sticky o_error built only with CGOL_BOARD_MEMORY_PROTOCOL_CHECK_EN.
module cgol_board_memory #(
    parameter logic [63:0] INIT_BOARD = 64'h0000_0000_0000_0000,
    parameter int          ROWS       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  memory_operation,
    input  logic [5:0]  memory_operation_address,
    input  logic        i_data,
    input  logic [1:0]  i_state_top,
    output logic        o_data,
    output logic        o_done,
    output logic [63:0] o_board,
    output logic        o_error
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_GAME  = 2'b00;
    localparam logic [1:0] ST_CYCLE = 2'b01;
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    typedef enum logic [1:0] {SERVE, COPY, DONE, HOLD} fsm_t;

    fsm_t        fsm;
    logic [2:0]  row_cnt;
    logic [1:0]  prev_state_top;
    logic [63:0] read_bank;
    logic [63:0] write_bank;
    logic        cycle_entry;

    assign cycle_entry = (i_state_top == ST_CYCLE) && (prev_state_top != ST_CYCLE);
    assign o_board     = read_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm            <= SERVE;
            row_cnt        <= 3'd0;
            prev_state_top <= ST_GAME;
            read_bank      <= INIT_BOARD;
            write_bank     <= 64'd0;
            o_data         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            prev_state_top <= i_state_top;
            o_done         <= 1'b0;
            case (fsm)
                SERVE: begin
                    if (memory_operation == OP_READ)
                        o_data <= read_bank[memory_operation_address];
                    else if (memory_operation == OP_WRITE)
                        write_bank[memory_operation_address] <= i_data;
                    if (cycle_entry) begin
                        fsm     <= COPY;
                        row_cnt <= 3'd0;
                    end
                end
                COPY: begin
                    read_bank[{row_cnt, 3'b000} +: 8] <= write_bank[{row_cnt, 3'b000} +: 8];
                    row_cnt <= row_cnt + 3'd1;
                    o_data  <= 1'b0;
                    if (row_cnt == LAST_ROW)
                        fsm <= DONE;
                end
                DONE: begin
                    // Registered pulse: visible during the clock after DONE, 9 edges after entry.
                    o_done <= 1'b1;
                    fsm    <= HOLD;
                end
                HOLD: begin
                    if (i_state_top != ST_CYCLE)
                        fsm <= SERVE;
                end
                default: fsm <= SERVE;
            endcase
        end
    end

`ifdef CGOL_BOARD_MEMORY_PROTOCOL_CHECK_EN
    localparam logic [1:0] OP_RSVD = 2'b11;

    logic op_access;
    logic violation;

    assign op_access = (memory_operation == OP_READ) || (memory_operation == OP_WRITE);
    assign violation = (fsm == SERVE)
                     ? ((memory_operation == OP_RSVD) ||
                        ((memory_operation == OP_WRITE) && (i_state_top != ST_GAME)))
                     : op_access;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_error <= 1'b0;
        else if (violation)
            o_error <= 1'b1;
    end
`else
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_cgol_board_memory.sv
// Bench for cgol_board_memory: vector table, copy-sequence corner cases and random ops against a bank-level model.
module tb_cgol_board_memory;

    localparam logic [63:0] INIT = 64'h1;
`ifdef CGOL_BOARD_MEMORY_PROTOCOL_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  memory_operation;
    logic [5:0]  memory_operation_address;
    logic        i_data;
    logic [1:0]  i_state_top;
    logic        o_data;
    logic        o_done;
    logic [63:0] o_board;
    logic        o_error;

    cgol_board_memory #(.INIT_BOARD(INIT), .ROWS(8)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .memory_operation         (memory_operation),
        .memory_operation_address (memory_operation_address),
        .i_data                   (i_data),
        .i_state_top              (i_state_top),
        .o_data                   (o_data),
        .o_done                   (o_done),
        .o_board                  (o_board),
        .o_error                  (o_error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] rd_m;
    logic [63:0] wr_m;
    logic        exp_odata;

    typedef struct {
        logic [1:0] op;
        logic [5:0] a;
        logic       d;
        logic       exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        rd_m      = INIT;
        wr_m      = 64'd0;
        exp_odata = 1'b0;
    endtask

    // One SERVE-state operation; the model is updated from the bank rules.
    task automatic serve_op(input logic [1:0] op, input logic [5:0] a, input logic d);
        memory_operation         = op;
        memory_operation_address = a;
        i_data                   = d;
        step();
        if (op == 2'b00) exp_odata = rd_m[a];
        else if (op == 2'b01) wr_m[a] = d;
        memory_operation = 2'b10;
    endtask

    // Entry edge, then 9 edges; leave_at > 0 drops CYCLE_REGISTERS after that many COPY edges.
    task automatic cycle_copy(input int leave_at);
        logic [63:0] old;
        logic [63:0] mask;
        int          early;
        old   = rd_m;
        early = 0;
        i_state_top = 2'b01;
        step();
        for (int k = 1; k <= 9; k++) begin
            if (leave_at > 0 && k - 1 == leave_at) i_state_top = 2'b00;
            step();
            if (k <= 8) begin
                mask = (k == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * k)) - 64'd1);
                chk($sformatf("copy_rows_k%0d", k), o_board, (old & ~mask) | (wr_m & mask));
                if (o_done) early++;
            end
        end
        chk("done_before_9", 64'(early), 64'd0);
        chk("done_at_9", 64'(o_done), 64'd1);
        rd_m      = wr_m;
        exp_odata = 1'b0;
    endtask

    initial begin
        vec_t        tbl[9];
        logic [63:0] pat;
        int          pulses;

        rst = 1'b1;
        memory_operation = 2'b10;
        memory_operation_address = 6'd0;
        i_data = 1'b0;
        i_state_top = 2'b00;
        model_reset();
        #1;
        chk("rst_o_data", 64'(o_data), 64'd0);
        chk("rst_o_done", 64'(o_done), 64'd0);
        chk("rst_o_board", o_board, INIT);
        chk("rst_o_error", 64'(o_error), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Vector table: reads see only the read bank; writes and idles leave o_data alone.
        tbl = '{
            '{2'b00, 6'd0,  1'b0, 1'b1},
            '{2'b00, 6'd1,  1'b0, 1'b0},
            '{2'b01, 6'd63, 1'b1, 1'b0},
            '{2'b00, 6'd63, 1'b0, 1'b0},
            '{2'b10, 6'd0,  1'b0, 1'b0},
            '{2'b00, 6'd0,  1'b0, 1'b1},
            '{2'b10, 6'd5,  1'b0, 1'b1},
            '{2'b01, 6'd2,  1'b1, 1'b1},
            '{2'b00, 6'd2,  1'b0, 1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            serve_op(tbl[i].op, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d", i), 64'(o_data), 64'(tbl[i].exp));
        end
        chk("board_init", o_board, INIT);

        // First copy: bit 63 becomes visible only after the cycle.
        cycle_copy(0);
        i_state_top = 2'b00;
        step();
        chk("done_width", 64'(o_done), 64'd0);
        chk("board63", 64'(o_board[63]), 64'd1);
        serve_op(2'b00, 6'd63, 1'b0);
        chk("read63", 64'(o_data), 64'(exp_odata));

        // Checkerboard, then hold CYCLE_REGISTERS with no second copy.
        pat = 64'hAA55_AA55_AA55_AA55;
        for (int a = 0; a < 64; a++) serve_op(2'b01, 6'(a), pat[a]);
        cycle_copy(0);
        pulses = 0;
        repeat (20) begin
            step();
            if (o_done) pulses++;
        end
        chk("no_second_done", 64'(pulses), 64'd0);
        chk("board_pat", o_board, pat);
        i_state_top = 2'b00;
        step();

        // Reset during the 4th COPY cycle.
        i_state_top = 2'b01;
        step();
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("midcopy_board", o_board, INIT);
        i_state_top = 2'b00;
        pulses = 0;
        repeat (3) begin
            step();
            if (o_done) pulses++;
        end
        rst = 1'b0;
        model_reset();
        repeat (10) begin
            step();
            if (o_done) pulses++;
        end
        chk("midcopy_no_done", 64'(pulses), 64'd0);
        serve_op(2'b00, 6'd0, 1'b0);
        chk("post_rst_read", 64'(o_data), 64'd1);
        chk("err_clean", 64'(o_error), 64'd0);

        // Random SERVE traffic followed by a copy, three rounds.
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 40; n++) begin
                serve_op(2'($urandom_range(0, 2)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
                chk($sformatf("rnd_r%0d_n%0d", r, n), 64'(o_data), 64'(exp_odata));
            end
            serve_op(2'b01, 6'd7, 1'b1);
            if (r == 0) begin
                chk("err_before_hold", 64'(o_error), 64'd0);
                cycle_copy(2);
                // Read lands in HOLD (ignored), then SERVE resumes on the following edge.
                memory_operation = 2'b00;
                memory_operation_address = 6'd7;
                step();
                chk("hold_read_ignored", 64'(o_data), 64'd0);
                chk("hold_read_err", 64'(o_error), 64'(ERR_EN));
                step();
                memory_operation = 2'b10;
                exp_odata = rd_m[7];
                chk("serve_resumed", 64'(o_data), 64'd1);
            end else begin
                cycle_copy(0);
                i_state_top = 2'b00;
                step();
            end
            chk($sformatf("rnd_board_r%0d", r), o_board, wr_m);
        end

        // Reserved op in SERVE: sticky error only when checks are built.
        rst = 1'b1;
        #1;
        chk("err_rst_clear", 64'(o_error), 64'd0);
        step();
        rst = 1'b0;
        model_reset();
        serve_op(2'b11, 6'd0, 1'b0);
        chk("err_rsvd", 64'(o_error), 64'(ERR_EN));
        repeat (5) step();
        chk("err_sticky", 64'(o_error), 64'(ERR_EN));
        chk("rsvd_odata", 64'(o_data), 64'(exp_odata));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cgol_board_memory.md
Name: cgol_board_memory

Overview:
Responder end of the cell-logic memory interface. Holds two 64-cell boards: a read bank (current generation) served to READ_REG requests and a write bank (next generation) filled by WRITE_REG requests. When the top state machine enters CYCLE_REGISTERS, the block copies the write bank into the read bank row by row, then pulses done. It sits between the cell logic, the top FSM and the display path.

Parameters:
INIT_BOARD, 64'h0000_0000_0000_0000, read-bank contents loaded at reset; bit index = {row[2:0], col[2:0]}
ROWS, 8, rows copied per cycle operation; fixed at 8, 8 cells per row

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
memory_operation  input  2  00 READ_REG, 01 WRITE_REG, 10 IDLE, 11 reserved
memory_operation_address  input  6  cell address {row, col}
i_data  input  1  write data for WRITE_REG
i_state_top  input  2  top FSM state: 00 PROCESS_GAME_STATE, 01 CYCLE_REGISTERS, 10 PROCESS_OUTPUT, 11 PAUSE
o_data  output  1  registered read data
o_done  output  1  one-cycle pulse when the bank copy completes
o_board  output  64  read bank, continuously driven for display
o_error  output  1  sticky protocol-error flag (macro-gated; see Optional Feature)

Behaviour:
- Reset (async, active-high). Values while asserted:
  - read_bank = INIT_BOARD, write_bank = 0
  - o_data = 0, o_done = 0, o_error = 0
  - fsm = SERVE, row_cnt = 0, prev_state_top = PROCESS_GAME_STATE
- Reset mid-copy aborts the copy. No done pulse is produced. Banks reinitialise.
- FSM states: SERVE, COPY, DONE, HOLD.
- SERVE:
  - READ_REG: o_data <= read_bank[addr]. One-cycle latency; valid on the edge after the request and holds until the next READ_REG.
  - WRITE_REG: write_bank[addr] <= i_data at the clock edge. Repeated edges with the same op rewrite the same value.
  - IDLE or 11: no bank change; o_data holds.
  - Reads never see the write bank, so a generation's reads are unaffected by that generation's writes.
  - Transition: i_state_top == CYCLE_REGISTERS && prev_state_top != CYCLE_REGISTERS (rising entry) -> COPY, row_cnt <= 0.
- COPY:
  - Each cycle: read_bank[row_cnt*8 +: 8] <= write_bank[row_cnt*8 +: 8]; row_cnt <= row_cnt + 1.
  - All memory_operation values are ignored; o_data <= 0.
  - After row 7 (exactly 8 cycles) -> DONE. row_cnt wraps to 0 and is 3 bits wide.
- DONE: o_done = 1 for exactly this cycle, then -> HOLD.
- HOLD:
  - Ops are ignored.
  - Leaves to SERVE when i_state_top != CYCLE_REGISTERS.
  - Staying in CYCLE_REGISTERS never triggers a second copy.
- If i_state_top leaves CYCLE_REGISTERS during COPY, the copy still completes all 8 rows, pulses done, then returns to SERVE on the next cycle.
- prev_state_top is registered every cycle.
- The write bank is not cleared after a copy.
- o_board reflects read_bank directly; during COPY it shows a partially updated board, rows 0..row_cnt-1 new.
- Total cycle-operation latency: entry edge -> o_done high = 9 clocks (8 COPY + DONE).

Optional Feature:
Macro CGOL_BOARD_MEMORY_PROTOCOL_CHECK_EN.
- Defined: o_error is set sticky (cleared only by rst) on any of:
  - memory_operation == 11 in SERVE
  - WRITE_REG while i_state_top != PROCESS_GAME_STATE in SERVE
  - READ_REG or WRITE_REG in COPY, DONE or HOLD
- Undefined: o_error is tied to 0 and no check logic is synthesised.

Test Plan:
- INIT_BOARD=64'h1; release rst; READ_REG addr 0 -> o_data 1 one clock later; READ_REG addr 1 -> 0; o_board == 64'h1.
- Reads and writes, then copy:
  - WRITE_REG addr 63, i_data=1; READ_REG 63 -> o_data 0 (read bank unchanged).
  - i_state_top 00->01 -> o_done pulses once exactly 9 clocks after entry.
  - o_board[63] == 1, READ_REG 63 -> 1.
- Write the full checkerboard 64'hAA55_AA55_AA55_AA55 into the write bank, then cycle:
  - During COPY, o_board rows update one per clock.
  - Final o_board == pattern.
  - Hold CYCLE_REGISTERS 20 clocks -> no second o_done.
- Assert rst on the 4th COPY cycle:
  - o_board returns to INIT_BOARD immediately.
  - o_done never pulses.
  - After release, READ_REG works.
- i_state_top returns to 00 after 2 COPY cycles -> copy completes, o_done pulses at cycle 9, SERVE resumes at cycle 10.
- With CGOL_BOARD_MEMORY_PROTOCOL_CHECK_EN:
  - op 11 in SERVE -> o_error 1 and stays 1 until rst.
  - Without the macro, same stimulus -> o_error 0.
